uart_receiver: RTL and testbench

Byte-wide RS-232 receiver, the receive-side counterpart of `uart_sender`. It runs at 50 MHz and uses the same `baud_set` code table. It deserialises 8N1 frames from an asynchronous line using 16x oversampling with 3-sample majority voting, and presents each byte with a one-cycle done strobe. It feeds the command/parameter path inside `uart_dparm` and is also usable as a bench monitor on any `Rs232_Tx` line.

---
 rtl/uart_receiver.sv | 179 +++++++++++++++++
 tb/tb_uart_receiver.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : uart_receiver
//  Purpose  : 8N1 RS-232 receiver. It uses 16x oversampling and a 3-sample
//             majority vote. Each good byte is presented with a one-cycle
//             Rx_Done strobe. A low stop bit gives a one-cycle Frame_Err.
//  Revision : 1.0  initial release
// ============================================================================
module uart_receiver #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [2:0] baud_set,
    input  logic       Rs232_Rx,
    output logic [7:0] data_byte,
    output logic       Rx_Done,
    output logic       Frame_Err,
    output logic       uart_state
);

    // Oversample divider reload values. A tick fires every DIV+1 clocks.
    localparam logic [8:0] c_DIV_9600   = 9'(CLK_FREQ / (16 * 9600)   - 1);
    localparam logic [8:0] c_DIV_19200  = 9'(CLK_FREQ / (16 * 19200)  - 1);
    localparam logic [8:0] c_DIV_38400  = 9'(CLK_FREQ / (16 * 38400)  - 1);
    localparam logic [8:0] c_DIV_57600  = 9'(CLK_FREQ / (16 * 57600)  - 1);
    localparam logic [8:0] c_DIV_115200 = 9'(CLK_FREQ / (16 * 115200) - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic [2:0]  warm_q;
    logic [2:0]  baud_q, baud_d;
    logic [8:0]  div_q, div_d;
    logic [3:0]  sub_q, sub_d;
    logic [2:0]  bit_q, bit_d;
    logic        smp6_q, smp6_d, smp7_q, smp7_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        ferr_q, ferr_d;

    logic [8:0]  w_div_lim;
    logic        w_fall, w_tick, w_maj, w_mid, w_end;

    // Edges only count once the edge-detect flop holds a real pin sample.
    // This stops the reset value of 1 from creating a start edge when the
    // line is held low through reset.
    assign w_fall = warm_q[2] & rx_prev_q & ~rx_s2_q;
    assign w_tick = (state_q != S_IDLE) && (div_q == w_div_lim);
    assign w_maj  = (smp6_q & smp7_q) | (smp6_q & rx_s2_q) | (smp7_q & rx_s2_q);
    assign w_mid  = w_tick && (sub_q == 4'd8);
    assign w_end  = w_tick && (sub_q == 4'd15);

    // Select the divider limit from the baud code latched at frame start.
    always_comb begin
        case (baud_q)
            3'd1:    w_div_lim = c_DIV_19200;
            3'd2:    w_div_lim = c_DIV_38400;
            3'd3:    w_div_lim = c_DIV_57600;
            3'd4:    w_div_lim = c_DIV_115200;
            default: w_div_lim = c_DIV_9600;
        endcase
    end

    // Next-state logic: divider, sub-tick and bit counters, voting, framing.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        div_d   = div_q;
        sub_d   = sub_q;
        bit_d   = bit_q;
        smp6_d  = smp6_q;
        smp7_d  = smp7_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;

        if (state_q == S_IDLE) begin
            div_d = 9'd0;
            if (w_fall) begin
                state_d = S_START;
                sub_d   = 4'd0;
                bit_d   = 3'd0;
                baud_d  = baud_set;
            end
        end else begin
            div_d = w_tick ? 9'd0 : div_q + 9'd1;
            if (w_tick) begin
                sub_d = sub_q + 4'd1;
                if (sub_q == 4'd6) smp6_d = rx_s2_q;
                if (sub_q == 4'd7) smp7_d = rx_s2_q;
            end

            case (state_q)
                S_START: begin
                    // A high vote at mid-start means the edge was a glitch.
                    if (w_mid && w_maj) begin
                        state_d = S_IDLE;
                    end else if (w_end) begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_mid) shreg_d[bit_q] = w_maj;
                    if (w_end) begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    // Leave at mid-stop so a slightly fast sender's next start
                    // edge is not missed.
                    if (w_mid) begin
                        state_d = S_IDLE;
                        if (w_maj) begin
                            data_d = shreg_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, synchronizer and datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            warm_q    <= 3'd0;
            baud_q    <= 3'd0;
            div_q     <= 9'd0;
            sub_q     <= 4'd0;
            bit_q     <= 3'd0;
            smp6_q    <= 1'b0;
            smp7_q    <= 1'b0;
            shreg_q   <= 8'h00;
            data_q    <= 8'h00;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_s1_q   <= Rs232_Rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            warm_q    <= {warm_q[1:0], 1'b1};
            baud_q    <= baud_d;
            div_q     <= div_d;
            sub_q     <= sub_d;
            bit_q     <= bit_d;
            smp6_q    <= smp6_d;
            smp7_q    <= smp7_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    assign data_byte  = data_q;
    assign Rx_Done    = done_q;
    assign Frame_Err  = ferr_q;
    assign uart_state = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_receiver
//  Purpose  : Self-checking bench for uart_receiver. It drives serial frames
//             and compares strobes against a frame-level scoreboard model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] baud;
    logic       rx;
    logic [7:0] data_byte;
    logic       rx_done, frame_err, uart_state;

    uart_receiver #(.CLK_FREQ(50_000_000)) dut (
        .Clk        (clk),
        .Rst        (rst),
        .baud_set   (baud),
        .Rs232_Rx   (rx),
        .data_byte  (data_byte),
        .Rx_Done    (rx_done),
        .Frame_Err  (frame_err),
        .uart_state (uart_state)
    );

    always #10 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         err;
        logic [7:0] data;
        longint     t;
    } ev_t;

    typedef struct {
        bit         err;
        logic [7:0] data;
        longint     t0;
        int         bp;
    } exp_t;

    typedef struct {
        logic [7:0] b;
        int         code;
        bit         stop;
        int         gap;
        bit         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    ev_t        ev_q[$];
    exp_t       exp_q[$];
    logic [7:0] last_good = 8'h00;
    longint     rise_t = -1, fall_t = -1;
    longint     t0;
    logic       prev_done = 1'b0, prev_err = 1'b0, prev_st = 1'b0;

    // Monitor: capture strobes and uart_state edges away from the clock edge.
    always @(negedge clk) begin
        if (rx_done || frame_err) begin
            total++;
            if ((rx_done && frame_err) || (rx_done && prev_done) || (frame_err && prev_err)) begin
                bad++;
                $display("FAIL strobe_shape: done=%0b err=%0b prev_done=%0b prev_err=%0b, required single exclusive pulse",
                         rx_done, frame_err, prev_done, prev_err);
            end
            ev_q.push_back('{frame_err, data_byte, cyc});
        end
        if (uart_state && !prev_st) rise_t = cyc;
        if (!uart_state && prev_st) fall_t = cyc;
        prev_done = rx_done;
        prev_err  = frame_err;
        prev_st   = uart_state;
    end

    function automatic int bp_of(input int code);
        case (code)
            1:       return 2592;
            2:       return 1296;
            3:       return 864;
            4:       return 432;
            default: return 5200;
        endcase
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  data_byte,  0);
        check({tag, "_done"},  rx_done,    0);
        check({tag, "_err"},   frame_err,  0);
        check({tag, "_state"}, uart_state, 0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame. flip_at inverts the line for one clock at that
    // offset; abort_at stops driving and returns the line to idle; scramble
    // changes baud_set mid-frame.
    task automatic send_frame(input logic [7:0] b, input int code, input bit stop,
                              input int flip_at, input int abort_at, input bit scramble,
                              output longint ts);
        int         bp;
        int         off;
        logic [9:0] bits;
        bp   = bp_of(code);
        bits = {stop, b, 1'b0};
        baud = 3'(code);
        ts   = cyc;
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < bp; k++) begin
                off = i * bp + k;
                if (off == abort_at) begin
                    rx = 1'b1;
                    return;
                end
                rx = bits[i] ^ (off == flip_at);
                if (scramble && off == 2 * bp) baud = 3'($urandom);
                @(posedge clk);
                #1;
            end
        end
        rx = 1'b1;
    endtask

    // Reference model: a frame either delivers its byte or reports a framing
    // error while the output keeps the last good byte.
    task automatic model_frame(input logic [7:0] b, input bit stop, input longint ts, input int code);
        if (stop) begin
            exp_q.push_back('{1'b0, b, ts, bp_of(code)});
            last_good = b;
        end else begin
            exp_q.push_back('{1'b1, last_good, ts, bp_of(code)});
        end
    endtask

    // Scoreboard: compare observed strobes with the expected frame outcomes.
    task automatic drain();
        exp_t   e;
        ev_t    v;
        longint lat;
        for (int i = 0; i < 50 && ev_q.size() < exp_q.size(); i++) tick(1);
        check("strobe_count", ev_q.size(), exp_q.size());
        while (exp_q.size() > 0 && ev_q.size() > 0) begin
            e   = exp_q.pop_front();
            v   = ev_q.pop_front();
            check("strobe_kind", v.err, e.err);
            check("strobe_data", v.data, e.data);
            lat = 3 + 9 * e.bp + 9 * (e.bp / 16);
            check_range("strobe_latency", v.t - e.t0, lat - 2, lat + 2);
        end
        exp_q.delete();
        ev_q.delete();
        check("data_hold", data_byte, last_good);
    endtask

    vec_t       tbl[6];
    logic       seen;
    logic [7:0] rb;
    int         rcode, rgap;
    bit         rstop;

    initial begin
        tbl[0] = '{8'haa, 3, 1'b1, 200, 1'b0, 8'haa};
        tbl[1] = '{8'h55, 4, 1'b1, 200, 1'b0, 8'h55};
        tbl[2] = '{8'h33, 4, 1'b1, 200, 1'b0, 8'h33};
        tbl[3] = '{8'haf, 4, 1'b1, 200, 1'b0, 8'haf};
        tbl[4] = '{8'h11, 4, 1'b1, 200, 1'b0, 8'h11};
        tbl[5] = '{8'hc3, 4, 1'b0, 200, 1'b1, 8'h11};

        // Line held low through reset must not start a frame.
        rst  = 1'b1;
        rx   = 1'b0;
        baud = 3'd0;
        tick(10);
        check_reset_outputs("reset");
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            seen = seen | uart_state | rx_done | frame_err;
        end
        check("low_line_idle", seen, 0);
        rx = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            seen = seen | uart_state | rx_done | frame_err;
        end
        check("raised_line_idle", seen, 0);
        drain();

        // Directed frames from the table, including a bad stop bit.
        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].b, tbl[i].code, tbl[i].stop, -1, -1, 1'b0, t0);
            exp_q.push_back('{tbl[i].exp_err, tbl[i].exp_data, t0, bp_of(tbl[i].code)});
            if (!tbl[i].exp_err) last_good = tbl[i].exp_data;
            tick(tbl[i].gap);
            drain();
        end

        // Back-to-back frames at the fastest rate.
        send_frame(8'h00, 4, 1'b1, -1, -1, 1'b0, t0);
        model_frame(8'h00, 1'b1, t0, 4);
        send_frame(8'hff, 4, 1'b1, -1, -1, 1'b0, t0);
        model_frame(8'hff, 1'b1, t0, 4);
        tick(50);
        drain();

        // Short low glitches at code 0 and at code 7 (which aliases to 0).
        for (int g = 0; g < 2; g++) begin
            baud = (g == 0) ? 3'd0 : 3'd7;
            tick(5);
            rise_t = -1;
            fall_t = -1;
            t0     = cyc;
            rx     = 1'b0;
            tick(100);
            rx     = 1'b1;
            tick(2900);
            check("glitch_rise", rise_t - t0, 3);
            check_range("glitch_idle", fall_t - t0, 2920, 2928);
            drain();
        end

        // One-clock inverted pulse on a mid-bit voting sample of bit 3.
        send_frame(8'h5a, 4, 1'b1, 4 * 432 + 216, -1, 1'b0, t0);
        model_frame(8'h5a, 1'b1, t0, 4);
        tick(100);
        drain();

        // Reset during bit 4 discards the frame; the next one is received.
        fork
            send_frame(8'h77, 4, 1'b1, -1, 5 * 432 + 216, 1'b0, t0);
            begin
                tick(5 * 432 + 216);
                check("busy_before_rst", uart_state, 1);
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
                check_reset_outputs("midframe_rst");
            end
        join
        last_good = 8'h00;
        tick(10 * 432);
        drain();
        send_frame(8'h99, 4, 1'b1, -1, -1, 1'b0, t0);
        model_frame(8'h99, 1'b1, t0, 4);
        tick(100);
        drain();

        // Random frames with mid-frame baud_set changes and random gaps.
        for (int n = 0; n < 3; n++) begin
            rb    = 8'($urandom);
            rcode = ($urandom_range(0, 3) == 0) ? 3 : 4;
            rstop = ($urandom_range(0, 4) != 0);
            rgap  = rstop ? $urandom_range(0, 300) : 20 + $urandom_range(0, 300);
            send_frame(rb, rcode, rstop, -1, -1, 1'b1, t0);
            model_frame(rb, rstop, t0, rcode);
            tick(rgap);
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
